// File: rtl/beat_sequencer_pkg.sv
// Shared widths, song defaults and FSM encoding for the piano-game beat sequencer.
package beat_sequencer_pkg;

  localparam int BEAT_W        = 7;
  localparam int NOTE_W        = 6;
  localparam int BEATS_DEFAULT = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  function automatic logic is_active(input state_e st);
    return (st == ST_PLAY) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Game-control bundle between the sequencer (master) and judge/display/audio (slave).
interface beat_sequencer_if;
  import beat_sequencer_pkg::*;

  logic              start;
  logic              pause;
  logic              hit_pulse;
  logic [NOTE_W-1:0] expected_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [NOTE_W-1:0] hit_cnt;
  logic              beat_tick;
  logic              stray;
  logic              playing;
  logic              win;
  logic              lose;

  modport master (
    input  start, pause, hit_pulse, expected_cnt,
    output beat_cnt, hit_cnt, beat_tick, stray, playing, win, lose
  );

  modport slave (
    output start, pause, hit_pulse, expected_cnt,
    input  beat_cnt, hit_cnt, beat_tick, stray, playing, win, lose
  );

endinterface

// File: rtl/beat_sequencer_tempo_divider.sv
// Tick counter pacing beats; beat_end flags the last enabled tick of a beat.
module beat_sequencer_tempo_divider #(
  parameter int TICKS_PER_BEAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic beat_end
);

  localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              last_tick;

  assign last_tick = (tick_q == TICK_W'(TICKS_PER_BEAT - 1));
  assign beat_end  = en && last_tick;

  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = last_tick ? '0 : tick_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Piano-game controller: paces beats, counts accepted hits, declares WIN or LOSE.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int BEATS          = BEATS_DEFAULT,
  parameter int TICKS_PER_BEAT = 4,
  parameter bit STRICT         = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  beat_sequencer_if.master   bus
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [NOTE_W-1:0] hit_q, hit_d;
  logic              beat_tick_q, beat_tick_d;
  logic              stray_q, stray_d;
  logic              playing_q, playing_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic              tick_en, beat_end;
  logic              hit_acc, stray_hit;
  logic [NOTE_W-1:0] hit_next;

  // Tick only advances in a PLAY cycle that is not overridden by start or pause.
  assign tick_en = !bus.start && (state_q == ST_PLAY) && !bus.pause;

  beat_sequencer_tempo_divider #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_tempo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.start),
    .en       (tick_en),
    .beat_end (beat_end)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    hit_d       = hit_q;
    beat_tick_d = 1'b0;
    stray_d     = 1'b0;
    hit_acc     = bus.hit_pulse && (hit_q < bus.expected_cnt);
    stray_hit   = bus.hit_pulse && !hit_acc;
    hit_next    = hit_acc ? hit_q + NOTE_W'(1) : hit_q;

    if (bus.start) begin
      state_d = ST_PLAY;
      beat_d  = BEAT_W'(1);
      hit_d   = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else begin
            hit_d = hit_next;
            if (stray_hit) begin
              stray_d = 1'b1;
              if (STRICT) state_d = ST_LOSE;
            end
            // The beat is judged with this cycle's accepted hit already counted.
            if (beat_end && !(stray_hit && STRICT)) begin
              if (hit_next < bus.expected_cnt) begin
                state_d = ST_LOSE;
              end else if (beat_q == BEAT_W'(BEATS)) begin
                state_d = ST_WIN;
              end else begin
                beat_d      = beat_q + BEAT_W'(1);
                beat_tick_d = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) state_d = ST_PLAY;
        end
        default: ;
      endcase
    end

    playing_d = is_active(state_d);
    win_d     = (state_d == ST_WIN);
    lose_d    = (state_d == ST_LOSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      hit_q       <= '0;
      beat_tick_q <= 1'b0;
      stray_q     <= 1'b0;
      playing_q   <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hit_q       <= hit_d;
      beat_tick_q <= beat_tick_d;
      stray_q     <= stray_d;
      playing_q   <= playing_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign bus.beat_cnt  = beat_q;
  assign bus.hit_cnt   = hit_q;
  assign bus.beat_tick = beat_tick_q;
  assign bus.stray     = stray_q;
  assign bus.playing   = playing_q;
  assign bus.win       = win_q;
  assign bus.lose      = lose_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: song lookup gives 44 notes on odd beats 3..89.
module tb_beat_sequencer;
  import beat_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_beat = 0;
  int   ticks_seen = 0;
  int   tick_during_pause = 0;

  always #5 clk = ~clk;

  beat_sequencer_if bus ();
  beat_sequencer_if lax ();

  beat_sequencer #(.BEATS(96), .TICKS_PER_BEAT(4), .STRICT(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_sequencer #(.BEATS(96), .TICKS_PER_BEAT(4), .STRICT(1'b0)) u_dut_lax (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lax)
  );

  // Song lookup: one new note due on every odd beat from 3 to 89.
  function automatic logic [NOTE_W-1:0] song_exp(input logic [BEAT_W-1:0] b);
    int e;
    if (b < 3) return '0;
    e = (int'(b) - 1) / 2;
    if (e > 44) e = 44;
    return NOTE_W'(e);
  endfunction

  function automatic bit hit_wanted(input int b);
    return (b >= 3) && (b <= 89) && (b % 2 == 1);
  endfunction

  assign bus.expected_cnt = song_exp(bus.beat_cnt);
  assign lax.expected_cnt = song_exp(lax.beat_cnt);

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.beat_tick) ticks_seen++;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cur_beat  = 1;
  endtask

  // Plays n full beats from tick 0, one hit at tick 0 of each beat where a note is due.
  task automatic play_beats(input int n, input bit with_hits);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 4; t++) begin
        bus.hit_pulse = with_hits && (t == 0) && hit_wanted(cur_beat);
        step();
        bus.hit_pulse = 1'b0;
      end
      cur_beat++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.hit_pulse = 1'b0;
    lax.start = 1'b0; lax.pause = 1'b0; lax.hit_pulse = 1'b0;

    // Reset state
    #12;
    check_val("rst beat_cnt", int'(bus.beat_cnt), 0);
    check_val("rst hit_cnt",  int'(bus.hit_cnt), 0);
    check_val("rst flags", int'({bus.beat_tick, bus.stray, bus.playing, bus.win, bus.lose}), 0);
    rst_n = 1'b1;
    step();
    check_val("idle playing", int'(bus.playing), 0);

    // No hits: beats 1,2 pass, beat 3 (one note due) is lost at its last tick
    do_start();
    check_val("start beat_cnt", int'(bus.beat_cnt), 1);
    check_val("start playing",  int'(bus.playing), 1);
    play_beats(2, 1'b0);
    check_val("nohit beat3", int'(bus.beat_cnt), 3);
    check_val("nohit lose early", int'(bus.lose), 0);
    for (int i = 0; i < 3; i++) step();
    check_val("nohit lose tick2", int'(bus.lose), 0);
    step();
    check_val("nohit lose", int'(bus.lose), 1);
    check_val("nohit lose beat", int'(bus.beat_cnt), 3);
    check_val("nohit playing", int'(bus.playing), 0);
    step();
    check_val("lose holds", int'(bus.lose), 1);

    // Hit on the beat_end cycle of beat 3 is counted before judging
    do_start();
    play_beats(2, 1'b0);
    for (int i = 0; i < 3; i++) step();
    bus.hit_pulse = 1'b1;
    step();
    bus.hit_pulse = 1'b0;
    check_val("lastcyc hit_cnt", int'(bus.hit_cnt), 1);
    check_val("lastcyc lose", int'(bus.lose), 0);
    check_val("lastcyc beat", int'(bus.beat_cnt), 4);
    check_val("lastcyc tick", int'(bus.beat_tick), 1);

    // Pause mid beat 5 for 10 cycles with presses that must be ignored
    do_start();
    play_beats(4, 1'b1);
    check_val("pre-pause beat", int'(bus.beat_cnt), 5);
    check_val("pre-pause hit", int'(bus.hit_cnt), 1);
    step();
    step();
    bus.pause = 1'b1;
    tick_during_pause = 0;
    for (int i = 0; i < 10; i++) begin
      bus.hit_pulse = (i % 2 == 1);
      step();
      if (bus.beat_tick || bus.stray) tick_during_pause++;
    end
    bus.hit_pulse = 1'b0;
    check_val("pause beat", int'(bus.beat_cnt), 5);
    check_val("pause hit ignored", int'(bus.hit_cnt), 1);
    check_val("pause no pulses", tick_during_pause, 0);
    check_val("pause playing", int'(bus.playing), 1);
    bus.pause = 1'b0;
    step();
    check_val("resume frozen", int'(bus.beat_cnt), 5);
    bus.hit_pulse = 1'b1;
    step();
    bus.hit_pulse = 1'b0;
    check_val("resume hit", int'(bus.hit_cnt), 2);
    check_val("resume beat", int'(bus.beat_cnt), 5);
    step();
    check_val("resume advance", int'(bus.beat_cnt), 6);
    check_val("resume tick", int'(bus.beat_tick), 1);

    // Stray press in beat 1, STRICT build ends the game
    do_start();
    bus.hit_pulse = 1'b1;
    step();
    bus.hit_pulse = 1'b0;
    check_val("strict stray", int'(bus.stray), 1);
    check_val("strict lose", int'(bus.lose), 1);
    check_val("strict hit_cnt", int'(bus.hit_cnt), 0);
    step();
    check_val("strict stray pulse", int'(bus.stray), 0);

    // Same press on the lenient build: flagged, play continues
    lax.start = 1'b1;
    step();
    lax.start = 1'b0;
    lax.hit_pulse = 1'b1;
    step();
    lax.hit_pulse = 1'b0;
    check_val("lax stray", int'(lax.stray), 1);
    check_val("lax lose", int'(lax.lose), 0);
    check_val("lax playing", int'(lax.playing), 1);
    for (int i = 0; i < 3; i++) step();
    check_val("lax beat2", int'(lax.beat_cnt), 2);
    check_val("lax hit_cnt", int'(lax.hit_cnt), 0);

    // Full song with every note hit
    do_start();
    ticks_seen = 0;
    for (int b = 1; b <= 96; b++) begin
      if (b % 16 == 1) check_val($sformatf("song beat %0d", b), int'(bus.beat_cnt), b);
      play_beats(1, 1'b1);
    end
    check_val("win", int'(bus.win), 1);
    check_val("win lose", int'(bus.lose), 0);
    check_val("win hit_cnt", int'(bus.hit_cnt), 44);
    check_val("win beat_cnt", int'(bus.beat_cnt), 96);
    check_val("win beat_ticks", ticks_seen, 95);
    check_val("win playing", int'(bus.playing), 0);

    // Restart from WIN
    do_start();
    check_val("restart beat", int'(bus.beat_cnt), 1);
    check_val("restart hit", int'(bus.hit_cnt), 0);
    check_val("restart win", int'(bus.win), 0);

    // Asynchronous reset while playing beat 10
    play_beats(9, 1'b1);
    check_val("b10 beat", int'(bus.beat_cnt), 10);
    check_val("b10 hit", int'(bus.hit_cnt), 4);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst beat_cnt", int'(bus.beat_cnt), 0);
    check_val("arst hit_cnt", int'(bus.hit_cnt), 0);
    check_val("arst flags", int'({bus.beat_tick, bus.stray, bus.playing, bus.win, bus.lose}), 0);
    step();
    rst_n = 1'b1;
    step();
    check_val("post-rst idle beat", int'(bus.beat_cnt), 0);
    check_val("post-rst idle playing", int'(bus.playing), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
